// File: rtl/xor_unit_pkg.sv
// Shared constants and types for the xor_unit codebase slice.
// Imported by xor_bit_cell and xor_unit.
package xor_pkg;

  localparam int XOR_DEFAULT_WIDTH = 1;

  typedef logic [XOR_DEFAULT_WIDTH-1:0] xor_word_t;

endpackage

// File: rtl/xor_bit_cell.sv
// Single-bit combinational XOR cell; xor_unit builds its datapath from
// one of these per result bit.
module xor_bit_cell
  import xor_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_unit.sv
// Parameterised bitwise XOR with registered (COMB_OUT=0) or combinational
// (COMB_OUT=1) result and valid flag. Optional macro XOR_UNIT_PARITY_EN adds
// a parity output that tracks res.
module xor_unit
  import xor_pkg::*;
#(
  parameter int WIDTH    = XOR_DEFAULT_WIDTH,
  parameter int COMB_OUT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] res,
  output logic             res_valid
`ifdef XOR_UNIT_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic [WIDTH-1:0] xor_bits;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    xor_bit_cell u_cell (
      .a (a[i]),
      .b (b[i]),
      .y (xor_bits[i])
    );
  end

  if (COMB_OUT == 0) begin : g_reg
    logic [WIDTH-1:0] res_q;
    logic             valid_q;

    // res only loads on valid operands; the flag follows in_valid every edge
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        res_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= in_valid;
        if (in_valid) begin
          res_q <= xor_bits;
        end
      end
    end

    assign res       = res_q;
    assign res_valid = valid_q;

`ifdef XOR_UNIT_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        parity_q <= 1'b0;
      end else if (in_valid) begin
        parity_q <= ^xor_bits;
      end
    end

    assign parity = parity_q;
`endif
  end else begin : g_comb
    // Clock and reset play no part in the combinational variant
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign res       = xor_bits;
    assign res_valid = in_valid;

`ifdef XOR_UNIT_PARITY_EN
    assign parity = ^xor_bits;
`endif
  end

endmodule

// File: tb/tb_xor_unit.sv
// Self-checking bench for xor_unit: registered and combinational variants
// at WIDTH=1 and WIDTH=8, directed steps followed by random traffic.
module tb_xor_unit;

  logic       clk;
  logic       rst_n;
  logic       a1, b1, v1;
  logic [7:0] a8, b8;
  logic       v8;

  logic       r1, rv1, r1c, rv1c;
  logic [7:0] r8, r8c;
  logic       rv8, rv8c;
`ifdef XOR_UNIT_PARITY_EN
  logic       p1, p1c, p8, p8c;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Reference state for the registered instances
  logic       e1, ev1;
  logic [7:0] e8;
  logic       ev8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  xor_unit #(.WIDTH(1), .COMB_OUT(0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
    .res(r1), .res_valid(rv1)
`ifdef XOR_UNIT_PARITY_EN
    , .parity(p1)
`endif
  );

  xor_unit #(.WIDTH(1), .COMB_OUT(1)) u_w1c (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
    .res(r1c), .res_valid(rv1c)
`ifdef XOR_UNIT_PARITY_EN
    , .parity(p1c)
`endif
  );

  xor_unit #(.WIDTH(8), .COMB_OUT(0)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(v8),
    .res(r8), .res_valid(rv8)
`ifdef XOR_UNIT_PARITY_EN
    , .parity(p8)
`endif
  );

  xor_unit #(.WIDTH(8), .COMB_OUT(1)) u_w8c (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(v8),
    .res(r8c), .res_valid(rv8c)
`ifdef XOR_UNIT_PARITY_EN
    , .parity(p8c)
`endif
  );

  // Bitwise XOR from the definition: a result bit is 1 when the two operand bits sum to 1
  function automatic logic [63:0] ref_xor(input logic [63:0] x, input logic [63:0] y, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      if ((((x >> i) % 2) + ((y >> i) % 2)) % 2 == 1) r = r | (64'd1 << i);
    end
    return r;
  endfunction

  // Parity as the count of set bits modulo 2
  function automatic logic ref_par(input logic [63:0] x, input int w);
    int cnt;
    cnt = 0;
    for (int i = 0; i < w; i++) cnt += int'((x >> i) % 2);
    return (cnt % 2) == 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkComb();
    checkOutput("w1c_res", 64'(r1c), ref_xor(64'(a1), 64'(b1), 1));
    checkOutput("w1c_valid", 64'(rv1c), 64'(v1));
    checkOutput("w8c_res", 64'(r8c), ref_xor(64'(a8), 64'(b8), 8));
    checkOutput("w8c_valid", 64'(rv8c), 64'(v8));
`ifdef XOR_UNIT_PARITY_EN
    checkOutput("w1c_par", 64'(p1c), 64'(ref_par(ref_xor(64'(a1), 64'(b1), 1), 1)));
    checkOutput("w8c_par", 64'(p8c), 64'(ref_par(ref_xor(64'(a8), 64'(b8), 8), 8)));
`endif
  endtask

  task automatic checkReg();
    checkOutput("w1_res", 64'(r1), 64'(e1));
    checkOutput("w1_valid", 64'(rv1), 64'(ev1));
    checkOutput("w8_res", 64'(r8), 64'(e8));
    checkOutput("w8_valid", 64'(rv8), 64'(ev8));
`ifdef XOR_UNIT_PARITY_EN
    checkOutput("w1_par", 64'(p1), 64'(ref_par(64'(e1), 1)));
    checkOutput("w8_par", 64'(p8), 64'(ref_par(64'(e8), 8)));
`endif
  endtask

  // One clock cycle: drive at negedge, check comb outputs, then check registers after the edge
  task automatic applyStimulus(input logic a1_i, input logic b1_i, input logic v1_i,
                               input logic [7:0] a8_i, input logic [7:0] b8_i, input logic v8_i);
    @(negedge clk);
    a1 = a1_i; b1 = b1_i; v1 = v1_i;
    a8 = a8_i; b8 = b8_i; v8 = v8_i;
    #2;
    checkComb();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      e1 = 1'b0; ev1 = 1'b0; e8 = '0; ev8 = 1'b0;
    end else begin
      if (v1) e1 = ref_xor(64'(a1), 64'(b1), 1) != 0;
      ev1 = v1;
      if (v8) e8 = 8'(ref_xor(64'(a8), 64'(b8), 8));
      ev8 = v8;
    end
    checkReg();
  endtask

  initial begin
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
    a8 = '0; b8 = '0; v8 = 1'b0;
    e1 = 1'b0; ev1 = 1'b0; e8 = '0; ev8 = 1'b0;

    #1;
    checkReg();
    checkOutput("rst_w8_res", 64'(r8), 64'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] truth table, WIDTH=1");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b1);
    checkOutput("tt_00", 64'(r1), 64'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b1);
    checkOutput("tt_10", 64'(r1), 64'h1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b1);
    checkOutput("tt_01", 64'(r1), 64'h1);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b1);
    checkOutput("tt_11", 64'(r1), 64'h0);

    $display("[TB] back-to-back");
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    checkOutput("b2b_0", 64'(r1), 64'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    checkOutput("b2b_1", 64'(r1), 64'h1);
    checkOutput("b2b_1_valid", 64'(rv1), 64'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    checkOutput("b2b_2", 64'(r1), 64'h0);

    $display("[TB] WIDTH=8 capture and hold");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'hA5, 8'h0F, 1'b1);
    checkOutput("w8_a5", 64'(r8), 64'hAA);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h33, 8'h11, 1'b0);
    checkOutput("w8_hold", 64'(r8), 64'hAA);
    checkOutput("w8_hold_valid", 64'(rv8), 64'h0);
    checkOutput("w1_drop_valid", 64'(rv1), 64'h0);

    applyStimulus(1'b0, 1'b0, 1'b0, 8'hFF, 8'h01, 1'b1);
    checkOutput("w8_fe", 64'(r8), 64'hFE);
`ifdef XOR_UNIT_PARITY_EN
    checkOutput("par_fe", 64'(p8), 64'h1);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h03, 8'h00, 1'b1);
    checkOutput("w8_03", 64'(r8), 64'h03);
`ifdef XOR_UNIT_PARITY_EN
    checkOutput("par_03", 64'(p8), 64'h0);
`endif

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h5A, 8'h00, 1'b1);
    checkOutput("pre_rst", 64'(r1), 64'h1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    e1 = 1'b0; ev1 = 1'b0; e8 = '0; ev8 = 1'b0;
    checkReg();
    checkOutput("rst_comb_res", 64'(r1c), 64'h1);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hC3, 8'h0F, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_w1_res", 64'(r1), 64'h0);
    checkOutput("rel_w8_valid", 64'(rv8), 64'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hC3, 8'h0F, 1'b1);
    checkOutput("rel_first", 64'(r1), 64'h1);
    checkOutput("rel_w8", 64'(r8), 64'hCC);

    $display("[TB] random traffic");
    for (int n = 0; n < 200; n++) begin
      applyStimulus(1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
                    8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/xor_unit.md
Name: xor_unit

Overview:
- Parameterised bitwise two-operand XOR with a registered result and a valid flag.
- Serves as the XOR primitive in the CA2 datapath; the default WIDTH=1 gives the classic single-bit XOR gate with one-cycle latency.
- Downstream logic samples res when res_valid is high.

Parameters:
- WIDTH, 1, operand and result width in bits (legal range 1 to 64).
- COMB_OUT, 0, 1 drives res combinationally from a and b; 0 gives the registered result, latency 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  a and b are valid this cycle.
- res  output  WIDTH  a ^ b, bitwise.
- res_valid  output  1  res holds a valid result.

Behaviour:
- Reset (rst_n=0, asynchronous): res=0 and res_valid=0 immediately, independent of clk.
- Reset release: the first capture happens on the first rising clk edge after rst_n is high.
- COMB_OUT=0, capture rule: on each rising clk edge with in_valid=1, the res register loads a^b.
- COMB_OUT=0, valid flag: res_valid loads in_valid on every edge, so latency is 1 cycle.
- COMB_OUT=0, hold rule: when in_valid=0, res holds its last value and res_valid drops to 0.
- COMB_OUT=1: res = a ^ b continuously and res_valid = in_valid continuously; registers are unused and reset has no effect on res.
- Arithmetic: purely bitwise, no carry, res[i] = a[i] XOR b[i] for every i.
- X/Z inputs are not specified; the bench drives only 0/1.
- No backpressure; a new operand pair is accepted every cycle.
- Reset asserted mid-stream clears res and res_valid at once; the pending result is dropped.

Optional Feature:
- Macro XOR_UNIT_PARITY_EN.
- When defined: adds output port parity (1 bit), equal to the XOR-reduction of res and following the same timing and reset value (0) as res.
- When undefined: the parity port and its logic are absent.

Decomposition:
- Package xor_pkg: constant XOR_DEFAULT_WIDTH=1 and typedef xor_word_t (logic [XOR_DEFAULT_WIDTH-1:0]).
- One natural sub-module, xor_bit_cell: a 1-bit combinational XOR, instantiated WIDTH times with a generate loop.
- The top level adds the result register, the valid pipeline and the optional parity.

Test Plan:
- WIDTH=1, COMB_OUT=0: drive a=0,b=0 / a=1,b=0 / a=0,b=1 / a=1,b=1, each with in_valid=1, one per cycle -> res=0,1,1,0 one cycle later with res_valid=1.
- WIDTH=1, COMB_OUT=1: drive the same four pairs, sampled 10 time units after each change -> res=0,1,1,0 with no clock needed.
- Reset: after res=1, pull rst_n low between clock edges -> res=0 and res_valid=0 immediately; both stay 0 until the first valid edge after release.
- WIDTH=8, COMB_OUT=0: a=8'hA5, b=8'h0F, in_valid=1 -> res=8'hAA next cycle; then drop in_valid -> res holds 8'hAA and res_valid=0.
- XOR_UNIT_PARITY_EN defined, WIDTH=8: a=8'hFF, b=8'h01 -> res=8'hFE, parity=1; a=8'h03, b=8'h00 -> res=8'h03, parity=0.
- Back-to-back: in_valid=1 for 3 cycles with (1,1),(1,0),(0,0) -> res=0,1,0 on consecutive cycles with res_valid held at 1.
